icache_controller: RTL and testbench

ICACHE_CONTROLLER -- requirements
Module: icache_controller

---
 rtl/icache_pkg.sv | 27 ++
 rtl/icache_line_array.sv | 41 ++++
 rtl/icache_controller.sv | 132 +++++++++++++
 tb/tb_icache_controller.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE   = 2'd2
  } state_t;

  localparam int OFFSET_W = 4;

  localparam logic [1:0] WORD_SEL_0 = 2'b00;
  localparam logic [1:0] WORD_SEL_1 = 2'b01;
  localparam logic [1:0] WORD_SEL_2 = 2'b10;
  localparam logic [1:0] WORD_SEL_3 = 2'b11;

  // Byte 0 of a block lives in bits [7:0], so word 0 is the low 32 bits.
  function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] sel);
    case (sel)
      WORD_SEL_0: return blk[31:0];
      WORD_SEL_1: return blk[63:32];
      WORD_SEL_2: return blk[95:64];
      default:    return blk[127:96];
    endcase
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Line storage for the instruction cache: valid/tag/data per set,
// synchronous write and asynchronous read.
module icache_line_array #(
  parameter int NUM_SETS = 8,
  parameter int IDX_W    = $clog2(NUM_SETS),
  parameter int TAG_W    = 28 - IDX_W
) (
  input  logic               i_clk,
  input  logic               i_clr,
  input  logic               i_we,
  input  logic [IDX_W-1:0]   i_widx,
  input  logic [TAG_W-1:0]   i_wtag,
  input  logic [127:0]       i_wdata,
  input  logic [IDX_W-1:0]   i_ridx,
  output logic               o_valid,
  output logic [TAG_W-1:0]   o_tag,
  output logic [127:0]       o_data
);

  logic [NUM_SETS-1:0] r_valid;
  logic [TAG_W-1:0]    r_tag  [NUM_SETS];
  logic [127:0]        r_data [NUM_SETS];

  // Clearing only the valid bits is enough to invalidate; tags and data keep their values.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_widx] <= 1'b1;
    end
    if (i_we) begin
      r_tag[i_widx]  <= i_wtag;
      r_data[i_widx] <= i_wdata;
    end
  end

  assign o_valid = r_valid[i_ridx];
  assign o_tag   = r_tag[i_ridx];
  assign o_data  = r_data[i_ridx];

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller with a three-state refill FSM.
// Define ICACHE_PERF_CNT_EN to add the HIT_COUNT / MISS_COUNT outputs.
module icache_controller
  import icache_pkg::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic [31:0]  ADDRESS,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic [27:0]  MEM_BLOCK_ADDRESS,
  input  logic [127:0] MEM_READ_INST,
  input  logic         MEM_BUSYWAIT,
  output state_t       o_dbg_state
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]  HIT_COUNT,
  output logic [31:0]  MISS_COUNT
`endif
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 32 - OFFSET_W - IDX_W;

  state_t            r_state;
  state_t            w_next;
  logic [27:0]       r_addr;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_line_valid;
  logic [TAG_W-1:0]  w_line_tag;
  logic [127:0]      w_line_data;
  logic              w_hit;
  logic              w_we;
  logic              w_latch;
  logic              w_unused_addr;

  assign w_idx         = ADDRESS[OFFSET_W +: IDX_W];
  assign w_tag         = ADDRESS[31 -: TAG_W];
  assign w_unused_addr = ^ADDRESS[1:0];

  icache_line_array #(
    .NUM_SETS (NUM_SETS),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_lines (
    .i_clk   (CLOCK),
    .i_clr   (RESET),
    .i_we    (w_we),
    .i_widx  (r_addr[IDX_W-1:0]),
    .i_wtag  (r_addr[27 -: TAG_W]),
    .i_wdata (MEM_READ_INST),
    .i_ridx  (w_idx),
    .o_valid (w_line_valid),
    .o_tag   (w_line_tag),
    .o_data  (w_line_data)
  );

  // The cache stalls for the whole reset cycle so no stale line can answer.
  assign w_hit = (r_state == S_IDLE) && !RESET && w_line_valid && (w_line_tag == w_tag);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_addr <= ADDRESS[31:4];
      end
    end
  end

  // Memory handshake: MEM_READ is held with a stable block address until the
  // memory drops MEM_BUSYWAIT; MEM_READ_INST must stay valid through UPDATE.
  always_comb begin
    w_next            = r_state;
    BUSYWAIT          = 1'b1;
    MEM_READ          = 1'b0;
    MEM_BLOCK_ADDRESS = '0;
    w_we              = 1'b0;
    w_latch           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          BUSYWAIT = 1'b0;
        end else begin
          w_latch = 1'b1;
          w_next  = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        MEM_READ          = 1'b1;
        MEM_BLOCK_ADDRESS = r_addr;
        if (!MEM_BUSYWAIT) begin
          w_next = S_UPDATE;
        end
      end
      S_UPDATE: begin
        MEM_BLOCK_ADDRESS = r_addr;
        w_we              = !RESET;
        w_next            = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign INSTRUCTION = BUSYWAIT ? 32'h0 : word_sel(w_line_data, ADDRESS[3:2]);
  assign o_dbg_state = r_state;

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
    end else begin
      if (w_hit) begin
        HIT_COUNT <= HIT_COUNT + 32'd1;
      end
      if (w_latch) begin
        MISS_COUNT <= MISS_COUNT + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Self-checking bench for icache_controller against a set/tag reference model.
module tb_icache_controller;
  import icache_pkg::*;

  localparam int NUM_SETS = 8;

  logic         clk;
  logic         RESET;
  logic [31:0]  ADDRESS;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [27:0]  MEM_BLOCK_ADDRESS;
  logic [127:0] MEM_READ_INST;
  logic         MEM_BUSYWAIT;
  state_t       dbg_state;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  HIT_COUNT;
  logic [31:0]  MISS_COUNT;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [31:0] salt;

  // reference model: per-set valid, tag and block, plus event counts
  logic        m_valid [NUM_SETS];
  logic [31:0] m_tag   [NUM_SETS];
  logic [127:0] m_data [NUM_SETS];
  int          m_hits;
  int          m_misses;

  icache_controller #(.NUM_SETS(NUM_SETS)) dut (
    .CLOCK             (clk),
    .RESET             (RESET),
    .ADDRESS           (ADDRESS),
    .INSTRUCTION       (INSTRUCTION),
    .BUSYWAIT          (BUSYWAIT),
    .MEM_READ          (MEM_READ),
    .MEM_BLOCK_ADDRESS (MEM_BLOCK_ADDRESS),
    .MEM_READ_INST     (MEM_READ_INST),
    .MEM_BUSYWAIT      (MEM_BUSYWAIT),
    .o_dbg_state       (dbg_state)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .HIT_COUNT         (HIT_COUNT),
    .MISS_COUNT        (MISS_COUNT)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] mem_block(input logic [27:0] ba);
    logic [127:0] b;
    for (int i = 0; i < 4; i++) begin
      b[32*i +: 32] = ({4'h0, ba} * 32'h9E3779B1) ^ (salt + 32'(i) * 32'h01010101);
    end
    return b;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_SETS; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic do_reset();
    RESET        = 1'b1;
    MEM_BUSYWAIT = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
    model_clear();
  endtask

  // One fetch, starting just after a negedge and ending at the next free negedge.
  task automatic fetch(input logic [31:0] addr, input int mem_lat, input logic use_alt,
                       input logic [31:0] alt_addr, input string name, output logic was_hit);
    int idx, wsel, cyc, nrd;
    logic [27:0]  ba;
    logic [127:0] blk;
    logic [31:0]  exp_word;
    logic         exp_hit, done;
    ba       = addr[31:4];
    idx      = int'((addr / 16) % NUM_SETS);
    wsel     = int'((addr / 4) % 4);
    exp_hit  = m_valid[idx] && (m_tag[idx] == addr / (16 * NUM_SETS));
    ADDRESS  = addr;
    #1;
    was_hit = (BUSYWAIT === 1'b0);
    chk_cnt++;
    if (BUSYWAIT !== !exp_hit) $display("FAIL %s busywait addr=%h got=%b exp=%b", name, addr, BUSYWAIT, !exp_hit);
    else pass_cnt++;
    chk_cnt++;
    if (MEM_READ !== 1'b0 || MEM_BLOCK_ADDRESS !== 28'h0)
      $display("FAIL %s idle_mem addr=%h mem_read=%b blk=%h exp 0/0", name, addr, MEM_READ, MEM_BLOCK_ADDRESS);
    else pass_cnt++;
    if (exp_hit) begin
      exp_word = m_data[idx][32*wsel +: 32];
      chk_cnt++;
      if (INSTRUCTION !== exp_word) $display("FAIL %s hit_word addr=%h got=%h exp=%h", name, addr, INSTRUCTION, exp_word);
      else pass_cnt++;
      m_hits++;
    end else begin
      chk_cnt++;
      if (INSTRUCTION !== 32'h0) $display("FAIL %s miss_instr addr=%h got=%h exp=0", name, addr, INSTRUCTION);
      else pass_cnt++;
      m_misses++;
      cyc  = 0;
      nrd  = 0;
      done = 1'b0;
      while (!done && cyc < 60) begin
        @(negedge clk);
        cyc++;
        if (BUSYWAIT === 1'b0) begin
          done = 1'b1;
        end else begin
          chk_cnt++;
          if (INSTRUCTION !== 32'h0) $display("FAIL %s stall_instr cyc=%0d got=%h exp=0", name, cyc, INSTRUCTION);
          else pass_cnt++;
          if (MEM_READ === 1'b1) begin
            nrd++;
            chk_cnt++;
            if (MEM_BLOCK_ADDRESS !== ba) $display("FAIL %s blk_addr cyc=%0d got=%h exp=%h", name, cyc, MEM_BLOCK_ADDRESS, ba);
            else pass_cnt++;
            if (use_alt && nrd == 1) ADDRESS = alt_addr;
            if (nrd == mem_lat) begin
              MEM_BUSYWAIT  = 1'b0;
              MEM_READ_INST = mem_block(ba);
            end
          end else begin
            ADDRESS      = addr;
            MEM_BUSYWAIT = 1'b1;
          end
        end
      end
      blk          = mem_block(ba);
      exp_word     = blk[32*wsel +: 32];
      m_valid[idx] = 1'b1;
      m_tag[idx]   = addr / (16 * NUM_SETS);
      m_data[idx]  = blk;
      m_hits++;
      chk_cnt++;
      if (!done) $display("FAIL %s timeout addr=%h got=busy exp=complete", name, addr);
      else pass_cnt++;
      chk_cnt++;
      if (cyc != 2 + mem_lat) $display("FAIL %s latency addr=%h got=%0d exp=%0d", name, addr, cyc, 2 + mem_lat);
      else pass_cnt++;
      chk_cnt++;
      if (INSTRUCTION !== exp_word || MEM_READ !== 1'b0)
        $display("FAIL %s refill_word addr=%h got=%h/%b exp=%h/0", name, addr, INSTRUCTION, MEM_READ, exp_word);
      else pass_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    RESET        = 1'b1;
    MEM_BUSYWAIT = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_cnt++;
    if (dbg_state !== S_IDLE || BUSYWAIT !== 1'b1 || MEM_READ !== 1'b0 || INSTRUCTION !== 32'h0 || MEM_BLOCK_ADDRESS !== 28'h0)
      $display("FAIL reset_outputs got st=%0d bw=%b rd=%b ins=%h blk=%h exp 0/1/0/0/0",
               dbg_state, BUSYWAIT, MEM_READ, INSTRUCTION, MEM_BLOCK_ADDRESS);
    else pass_cnt++;
    RESET = 1'b0;
    model_clear();
  endtask

  task automatic test_first_fetch();
    logic h;
    fetch(32'h0000_0000, 2, 1'b0, 32'h0, "first_miss", h);
    chk_cnt++;
    if (h !== 1'b0) $display("FAIL first_miss hit got=%b exp=0", h);
    else pass_cnt++;
    fetch(32'h0000_000C, 1, 1'b0, 32'h0, "word3_hit", h);
    chk_cnt++;
    if (h !== 1'b1) $display("FAIL word3_hit hit got=%b exp=1", h);
    else pass_cnt++;
  endtask

  task automatic test_conflict();
    logic h;
    fetch(32'h0000_0000, 1, 1'b0, 32'h0, "conflict_a", h);
    fetch(32'h0000_0080, 3, 1'b0, 32'h0, "conflict_b", h);
    chk_cnt++;
    if (h !== 1'b0) $display("FAIL conflict_b hit got=%b exp=0", h);
    else pass_cnt++;
    fetch(32'h0000_0000, 1, 1'b0, 32'h0, "conflict_back", h);
    chk_cnt++;
    if (h !== 1'b0) $display("FAIL conflict_back hit got=%b exp=0", h);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_refill();
    logic h;
    do_reset();
    ADDRESS = 32'h0000_0200;
    #1;
    @(negedge clk);
    chk_cnt++;
    if (MEM_READ !== 1'b1) $display("FAIL abort_pre mem_read got=%b exp=1", MEM_READ);
    else pass_cnt++;
    RESET = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b1 || INSTRUCTION !== 32'h0)
      $display("FAIL abort_post got rd=%b bw=%b ins=%h exp 0/1/0", MEM_READ, BUSYWAIT, INSTRUCTION);
    else pass_cnt++;
    RESET = 1'b0;
    model_clear();
    fetch(32'h0000_0200, 2, 1'b0, 32'h0, "abort_refetch", h);
    chk_cnt++;
    if (h !== 1'b0) $display("FAIL abort_refetch hit got=%b exp=0", h);
    else pass_cnt++;
  endtask

  task automatic test_addr_change();
    logic h;
    do_reset();
    fetch(32'h0000_0010, 3, 1'b1, 32'h0000_0040, "addr_change", h);
    fetch(32'h0000_0014, 1, 1'b0, 32'h0, "line1_filled", h);
    chk_cnt++;
    if (h !== 1'b1) $display("FAIL line1_filled hit got=%b exp=1", h);
    else pass_cnt++;
    fetch(32'h0000_0040, 1, 1'b0, 32'h0, "line4_empty", h);
    chk_cnt++;
    if (h !== 1'b0) $display("FAIL line4_empty hit got=%b exp=0", h);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic h;
    logic [31:0] a, alt;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      a   = 32'($urandom_range(0, 31)) * 16 + 32'($urandom_range(0, 3)) * 4;
      alt = 32'($urandom_range(0, 1023)) * 4;
      fetch(a, $urandom_range(1, 4), ($urandom_range(0, 3) == 0), alt, "random", h);
    end
  endtask

`ifdef ICACHE_PERF_CNT_EN
  task automatic test_perf();
    logic h;
    do_reset();
    fetch(32'h0000_1000, 1, 1'b0, 32'h0, "perf_m0", h);
    fetch(32'h0000_1010, 2, 1'b0, 32'h0, "perf_m1", h);
    fetch(32'h0000_1020, 1, 1'b0, 32'h0, "perf_m2", h);
    fetch(32'h0000_1004, 1, 1'b0, 32'h0, "perf_h0", h);
    fetch(32'h0000_1018, 1, 1'b0, 32'h0, "perf_h1", h);
    chk_cnt++;
    if (MISS_COUNT !== 32'd3 || 32'(m_misses) !== 32'd3) $display("FAIL perf_miss got=%0d exp=3", MISS_COUNT);
    else pass_cnt++;
    chk_cnt++;
    if (HIT_COUNT !== 32'd5 || 32'(m_hits) !== 32'd5) $display("FAIL perf_hit got=%0d exp=5", HIT_COUNT);
    else pass_cnt++;
  endtask
`endif

  initial begin
    salt          = $urandom;
    RESET         = 1'b1;
    ADDRESS       = 32'h0;
    MEM_BUSYWAIT  = 1'b1;
    MEM_READ_INST = '0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_first_fetch();
    test_conflict();
    test_reset_mid_refill();
    test_addr_change();
    test_random();
`ifdef ICACHE_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
